// File: rtl/id_stage_pipe.sv
// id_stage_pipe: clocked RV32 decode stage.
// Decodes the IF/ID instruction, reads the register file (with a WB->ID
// bypass), builds the sign-extended immediate, detects load-use hazards and
// registers the result into the ID/EX register under a valid/ready handshake.
// Optional build macro: DEBUG_REGS_EN adds the flat dbg_regs register-file view.
module id_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_inst,
  input  logic [PC_W-1:0] if_pc,
  output logic            id_ready,
  input  logic            ex_ready,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [PC_W-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_imm,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_func3,
  output logic [6:0]      ex_func7,
`ifdef DEBUG_REGS_EN
  output logic [NREGS*XLEN-1:0] dbg_regs,
`endif
  output logic            illegal
);

  localparam int RW = $clog2(NREGS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [XLEN-1:0] regs [NREGS];

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] func3;
  logic [6:0] func7;
  assign opcode = if_inst[6:0];
  assign rd     = if_inst[11:7];
  assign func3  = if_inst[14:12];
  assign rs1    = if_inst[19:15];
  assign rs2    = if_inst[24:20];
  assign func7  = if_inst[31:25];

  logic use_rs1, use_rs2, use_rd, op_ok, idx_bad, hz, adv, dec_illegal;
  logic signed [31:0] imm32;
  logic [XLEN-1:0] imm, rs1_data, rs2_data;

  // Format classification, legality and immediate selection
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    op_ok   = 1'b1;
    imm32   = '0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        imm32   = {{20{if_inst[31]}}, if_inst[31:20]};
      end
      OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25],
                   if_inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        use_rd = 1'b1;
        imm32  = {if_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        use_rd = 1'b1;
        imm32  = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20],
                  if_inst[30:21], 1'b0};
      end
      OP_REG: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: ;
      default: op_ok = 1'b0;
    endcase
    idx_bad = (use_rs1 && int'(rs1) >= NREGS) ||
              (use_rs2 && int'(rs2) >= NREGS) ||
              (use_rd  && int'(rd)  >= NREGS);
    dec_illegal = ~op_ok | idx_bad;
  end

  // Size cast of a signed value sign-extends to XLEN
  assign imm = XLEN'(imm32);

  // Register-file reads: x0 and out-of-range indices read 0, WB bypass wins
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1 != 5'd0 && int'(rs1) < NREGS) begin
      if (wb_we && wb_rd == rs1) rs1_data = wb_data;
      else                       rs1_data = regs[rs1[RW-1:0]];
    end
    if (rs2 != 5'd0 && int'(rs2) < NREGS) begin
      if (wb_we && wb_rd == rs2) rs2_data = wb_data;
      else                       rs2_data = regs[rs2[RW-1:0]];
    end
  end

  // Load-use hazard against the entry currently in ID/EX
  always_comb begin
    hz = ex_valid && (ex_opcode == OP_LOAD) && (ex_rd != 5'd0) &&
         ((use_rs1 && ex_rd == rs1) || (use_rs2 && ex_rd == rs2));
  end

  assign adv      = ex_ready | ~ex_valid;
  assign id_ready = adv & ~hz & ~flush;

  // Register-file write port; x0 is never written so it stays 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_we && wb_rd != 5'd0) begin
      for (int i = 1; i < NREGS; i++)
        if (wb_rd == 5'(i)) regs[i] <= wb_data;
    end
  end

  // ID/EX pipeline register: flush > bubble > load > drain > hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_imm      <= '0;
      ex_opcode   <= '0;
      ex_func3    <= '0;
      ex_func7    <= '0;
      illegal     <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (adv && hz) begin
      ex_valid <= 1'b0;
    end else if (adv && if_valid) begin
      ex_valid    <= 1'b1;
      ex_pc       <= if_pc;
      ex_rs1_data <= rs1_data;
      ex_rs2_data <= rs2_data;
      ex_rs1      <= rs1;
      ex_rs2      <= rs2;
      ex_rd       <= rd;
      ex_imm      <= imm;
      ex_opcode   <= opcode;
      ex_func3    <= func3;
      ex_func7    <= func7;
      illegal     <= dec_illegal;
    end else if (adv) begin
      ex_valid <= 1'b0;
    end
  end

`ifdef DEBUG_REGS_EN
  for (genvar g = 0; g < NREGS; g++) begin : g_dbg
    assign dbg_regs[g*XLEN +: XLEN] = regs[g];
  end
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe (32- and 16-register builds).
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        ex_ready;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        id_ready, ex_valid, illegal;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode, ex_func7;
  logic [2:0]  ex_func3;

  logic        e_id_ready, e_ex_valid, e_illegal;
  logic [31:0] e_ex_pc, e_ex_rs1_data, e_ex_rs2_data, e_ex_imm;
  logic [4:0]  e_ex_rs1, e_ex_rs2, e_ex_rd;
  logic [6:0]  e_ex_opcode, e_ex_func7;
  logic [2:0]  e_ex_func3;

`ifdef DEBUG_REGS_EN
  logic [32*32-1:0] dbg_regs;
  logic [16*32-1:0] e_dbg_regs;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(32), .NREGS(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_imm(ex_imm), .ex_opcode(ex_opcode), .ex_func3(ex_func3),
    .ex_func7(ex_func7),
`ifdef DEBUG_REGS_EN
    .dbg_regs(dbg_regs),
`endif
    .illegal(illegal)
  );

  id_stage_pipe #(.XLEN(32), .NREGS(16), .PC_W(32)) dut_e (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .id_ready(e_id_ready), .ex_ready(ex_ready), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(e_ex_valid), .ex_pc(e_ex_pc), .ex_rs1_data(e_ex_rs1_data),
    .ex_rs2_data(e_ex_rs2_data), .ex_rs1(e_ex_rs1), .ex_rs2(e_ex_rs2),
    .ex_rd(e_ex_rd), .ex_imm(e_ex_imm), .ex_opcode(e_ex_opcode),
    .ex_func3(e_ex_func3), .ex_func7(e_ex_func7),
`ifdef DEBUG_REGS_EN
    .dbg_regs(e_dbg_regs),
`endif
    .illegal(e_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc);
    if_valid = 1'b1;
    if_inst  = inst;
    if_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_inst = '0; if_pc = '0;
    ex_ready = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    #12;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_ex_imm",   ex_imm,        32'd0);
    check("rst_ex_rd",    32'(ex_rd),    32'd0);
    check("rst_illegal",  32'(illegal),  32'd0);
    rst = 1'b0;
    ex_ready = 1'b1;

    // addi x5,x0,-1
    present(32'hFFF00293, 32'h100);
    #1 check("addi_id_ready", 32'(id_ready), 32'd1);
    tick();
    check("addi_ex_valid",  32'(ex_valid),  32'd1);
    check("addi_ex_rd",     32'(ex_rd),     32'd5);
    check("addi_ex_imm",    ex_imm,         32'hFFFFFFFF);
    check("addi_ex_opcode", 32'(ex_opcode), 32'h13);
    check("addi_rs1_data",  ex_rs1_data,    32'd0);
    check("addi_ex_pc",     ex_pc,          32'h100);
    check("addi_illegal",   32'(illegal),   32'd0);
    check("addi_e_illegal", 32'(e_illegal), 32'd0);

    // add x4,x3,x3 with simultaneous write of x3
    present(32'h00318233, 32'h104);
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234;
    tick();
    wb_we = 1'b0;
    check("byp_rs1_data", ex_rs1_data,     32'h1234);
    check("byp_rs2_data", ex_rs2_data,     32'h1234);
    check("add_ex_imm",   ex_imm,          32'd0);
    check("add_ex_func7", 32'(ex_func7),   32'd0);

    // lw x6,0(x1) then add x7,x6,x2
    present(32'h0000A303, 32'h108);
    tick();
    check("lw_ex_valid", 32'(ex_valid), 32'd1);
    check("lw_ex_rd",    32'(ex_rd),    32'd6);
    check("lw_func3",    32'(ex_func3), 32'd2);
    present(32'h002303B3, 32'h10C);
    #1 check("hz_id_ready", 32'(id_ready), 32'd0);
    tick();
    check("hz_bubble_valid", 32'(ex_valid), 32'd0);
    check("hz_hold_rd",      32'(ex_rd),    32'd6);
    check("hz_clear_ready",  32'(id_ready), 32'd1);
    tick();
    check("hz_add_valid", 32'(ex_valid), 32'd1);
    check("hz_add_rd",    32'(ex_rd),    32'd7);
    check("hz_add_rs1",   32'(ex_rs1),   32'd6);
    check("hz_add_rs2",   32'(ex_rs2),   32'd2);

    // immediates: beq -4, sw -8, lui, jal +2048
    present(32'hFE000EE3, 32'h110);
    tick();
    check("beq_imm", ex_imm, 32'hFFFFFFFC);
    present(32'hFE20AC23, 32'h114);
    tick();
    check("sw_imm", ex_imm, 32'hFFFFFFF8);
    present(32'h12345537, 32'h118);
    tick();
    check("lui_imm", ex_imm, 32'h12345000);
    present(32'h0010006F, 32'h11C);
    tick();
    check("jal_imm",   ex_imm,         32'h00000800);
    check("jal_valid", 32'(ex_valid),  32'd1);

    // back-pressure for 3 cycles, then flush
    ex_ready = 1'b0;
    present(32'hFFF00293, 32'h120);
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("stall_id_ready%0d", i), 32'(id_ready), 32'd0);
      tick();
      check($sformatf("stall_valid%0d", i), 32'(ex_valid), 32'd1);
      check($sformatf("stall_imm%0d", i),   ex_imm,        32'h00000800);
      check($sformatf("stall_pc%0d", i),    ex_pc,         32'h11C);
    end
    flush = 1'b1;
    #1 check("flush_id_ready", 32'(id_ready), 32'd0);
    tick();
    check("flush_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0;
    ex_ready = 1'b1;

    // write to x0 is ignored, also not bypassed
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    present(32'h00000433, 32'h124);
    tick();
    wb_we = 1'b0;
    check("x0_bypass", ex_rs1_data, 32'd0);
    present(32'h000184B3, 32'h128);
    tick();
    check("x3_stored", ex_rs1_data, 32'h1234);
    check("x0_read",   ex_rs2_data, 32'd0);

    // illegal opcode, and x20 in the 16-register build
    present(32'h0000007F, 32'h12C);
    tick();
    check("bad_opcode", 32'(illegal), 32'd1);
    present(32'h00100A13, 32'h130);
    tick();
    check("x20_legal32",  32'(illegal),   32'd0);
    check("x20_illegal16", 32'(e_illegal), 32'd1);
    check("x20_rd",       32'(ex_rd),     32'd20);

    // reset during a stall clears the entry
    if_valid = 1'b0;
    ex_ready = 1'b0;
    tick();
    check("pre_rst_valid", 32'(ex_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(ex_valid), 32'd0);
    check("midrst_rd",    32'(ex_rd),    32'd0);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
